// File: rtl/macc_mat_bank.sv
// macc_mat_bank
//   Matrix storage bank for the MACC accelerator. NUM_MAT independent channels.
//   Each channel has its own block RAM, an auto-incrementing write pointer and
//   an auto-incrementing read pointer. Both pointers walk a rows x cols shape
//   that is set at runtime. The RAM address is {row, col}.
//
//   Optional feature: define MACC_TRANSPOSE_EN to honour rd_mode, which selects
//   column-major read traversal per channel. When the macro is undefined, reads
//   are always row-major and no column-major counter logic is built.
//
// Ports
//   CLK, RST       clock (rising edge); synchronous active-high reset
//   cfg_we/cfg_sel load the shape (cfg_max_row, cfg_max_col = rows-1, cols-1)
//                  into channel cfg_sel; takes effect from the next cycle
//   ptr_clr[i]     rewind both pointers of channel i to (0,0); this beats wr_en/rd_en
//   wr_en[i]       write wr_data slice i at the write pointer, then advance
//   wr_last[i]     pulse: the write just consumed element (max_row, max_col)
//   rd_en[i]       read at the read pointer, then advance (latency 1)
//   rd_mode[i]     1 = column-major read traversal (only with MACC_TRANSPOSE_EN)
//   rd_data        registered read data; holds until the next read
//   rd_valid[i]    rd_en delayed by one cycle
//   rd_last[i]     aligned with rd_valid: this word ends the traversal
module macc_mat_bank #(
    parameter int NUM_MAT = 3,
    parameter int DATA_W  = 32,
    parameter int DIM_W   = 6,
    localparam int SEL_W  = (NUM_MAT > 1) ? $clog2(NUM_MAT) : 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      cfg_we,
    input  logic [SEL_W-1:0]          cfg_sel,
    input  logic [DIM_W-1:0]          cfg_max_row,
    input  logic [DIM_W-1:0]          cfg_max_col,
    input  logic [NUM_MAT-1:0]        ptr_clr,
    input  logic [NUM_MAT-1:0]        wr_en,
    input  logic [NUM_MAT*DATA_W-1:0] wr_data,
    output logic [NUM_MAT-1:0]        wr_last,
    input  logic [NUM_MAT-1:0]        rd_en,
    input  logic [NUM_MAT-1:0]        rd_mode,
    output logic [NUM_MAT*DATA_W-1:0] rd_data,
    output logic [NUM_MAT-1:0]        rd_valid,
    output logic [NUM_MAT-1:0]        rd_last
);
    localparam int DEPTH = 2 ** (2 * DIM_W);

`ifndef MACC_TRANSPOSE_EN
    // Without the transpose feature, rd_mode has no effect.
    logic rd_mode_unused;
    assign rd_mode_unused = ^rd_mode;
`endif

    for (genvar gi = 0; gi < NUM_MAT; gi++) begin : g_ch
        logic [DIM_W-1:0]  wrow_reg, wcol_reg, rrow_reg, rcol_reg;
        logic [DIM_W-1:0]  wrow_next, wcol_next, rrow_next, rcol_next;
        logic [DIM_W-1:0]  max_row_reg, max_col_reg;
        logic              wwrap, rwrap;
        logic              cfg_hit;
        logic              wr_fire;
        logic [DATA_W-1:0] mem [0:DEPTH-1];
        logic [DATA_W-1:0] rd_data_reg;
        logic              rd_valid_reg, rd_last_reg, wr_last_reg;

        // An out-of-range cfg_sel never matches any channel, so it is ignored.
        assign cfg_hit = cfg_we && (cfg_sel == SEL_W'(gi));
        assign wr_fire = wr_en[gi] && !ptr_clr[gi];

        // Write pointer: always row-major. The >= compares make a pointer that
        // lies outside a shrunk shape wrap at its next advance.
        always_comb begin
            wrow_next = wrow_reg;
            wcol_next = wcol_reg + 1'b1;
            wwrap     = 1'b0;
            if (wcol_reg >= max_col_reg) begin
                wcol_next = '0;
                if (wrow_reg >= max_row_reg) begin
                    wrow_next = '0;
                    wwrap     = 1'b1;
                end else begin
                    wrow_next = wrow_reg + 1'b1;
                end
            end
        end

        // Read pointer: row-major by default; column-major swaps the roles of
        // row and col.
        always_comb begin
            rrow_next = rrow_reg;
            rcol_next = rcol_reg;
            rwrap     = 1'b0;
`ifdef MACC_TRANSPOSE_EN
            if (rd_mode[gi]) begin
                rrow_next = rrow_reg + 1'b1;
                if (rrow_reg >= max_row_reg) begin
                    rrow_next = '0;
                    if (rcol_reg >= max_col_reg) begin
                        rcol_next = '0;
                        rwrap     = 1'b1;
                    end else begin
                        rcol_next = rcol_reg + 1'b1;
                    end
                end
            end else
`endif
            begin
                rcol_next = rcol_reg + 1'b1;
                if (rcol_reg >= max_col_reg) begin
                    rcol_next = '0;
                    if (rrow_reg >= max_row_reg) begin
                        rrow_next = '0;
                        rwrap     = 1'b1;
                    end else begin
                        rrow_next = rrow_reg + 1'b1;
                    end
                end
            end
        end

        // RAM write port. The read happens in the block below. A read and a
        // write to the same address in the same cycle therefore return the old
        // data (read-first).
        always_ff @(posedge CLK) begin
            if (!RST && wr_fire) begin
                mem[{wrow_reg, wcol_reg}] <= wr_data[gi*DATA_W +: DATA_W];
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                wrow_reg     <= '0;
                wcol_reg     <= '0;
                rrow_reg     <= '0;
                rcol_reg     <= '0;
                max_row_reg  <= '1;
                max_col_reg  <= '1;
                rd_data_reg  <= '0;
                rd_valid_reg <= 1'b0;
                rd_last_reg  <= 1'b0;
                wr_last_reg  <= 1'b0;
            end else begin
                rd_valid_reg <= 1'b0;
                rd_last_reg  <= 1'b0;
                wr_last_reg  <= 1'b0;
                if (cfg_hit) begin
                    max_row_reg <= cfg_max_row;
                    max_col_reg <= cfg_max_col;
                end
                if (ptr_clr[gi]) begin
                    wrow_reg <= '0;
                    wcol_reg <= '0;
                    rrow_reg <= '0;
                    rcol_reg <= '0;
                end else begin
                    if (wr_en[gi]) begin
                        wrow_reg    <= wrow_next;
                        wcol_reg    <= wcol_next;
                        wr_last_reg <= wwrap;
                    end
                    if (rd_en[gi]) begin
                        rd_data_reg  <= mem[{rrow_reg, rcol_reg}];
                        rd_valid_reg <= 1'b1;
                        rd_last_reg  <= rwrap;
                        rrow_reg     <= rrow_next;
                        rcol_reg     <= rcol_next;
                    end
                end
            end
        end

        assign rd_data[gi*DATA_W +: DATA_W] = rd_data_reg;
        assign rd_valid[gi] = rd_valid_reg;
        assign rd_last[gi]  = rd_last_reg;
        assign wr_last[gi]  = wr_last_reg;
    end

endmodule
